// File: rtl/add_sub_seq.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per cycle, LSB first,
// with a registered inter-chunk carry and carry/overflow/zero flags.
module add_sub_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("add_sub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_b_q, sum_q, sum_d;
    logic [CW-1:0]     count_q;
    logic              carry_q, cout_q, ovf_q, zero_q;
    logic [CHUNK-1:0]  a_chunk, b_chunk, s_chunk;
    logic              c_chunk;
    int unsigned       lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StBusy;
            StBusy:  if (count_q == LAST) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StDone);
    end

    // One chunk slice of the ripple add; the running sum is built in place.
    always_comb begin
        lo                      = 32'(count_q) * CHUNK;
        a_chunk                 = op_a_q[lo +: CHUNK];
        b_chunk                 = op_b_q[lo +: CHUNK];
        {c_chunk, s_chunk}      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        sum_d                   = sum_q;
        sum_d[lo +: CHUNK]      = s_chunk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (state_q == StIdle && in_valid) begin
            op_a_q  <= a;
            op_b_q  <= b ^ {WIDTH{m}};
            carry_q <= m;
            count_q <= '0;
        end else if (state_q == StBusy) begin
            sum_q   <= sum_d;
            carry_q <= c_chunk;
            count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
            if (count_q == LAST) begin
                cout_q <= c_chunk;
                ovf_q  <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                          (sum_d[WIDTH-1] != op_a_q[WIDTH-1]);
                zero_q <= (sum_d == '0);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
